// File: rtl/bmp_header_gen.sv
// bmp_header_gen
// ---------------------------------------------------------------------------
// Writes the 54-byte header of an uncompressed BMP file into memory for a
// cropped region of an image. The header carries the crop size, row padding
// and total file size, so it is computed from the latched crop bounds.
//
// Parameters:
//   COORD_W   width of the crop coordinates
//   ADDR_W    width of the write address
//   DATA_W    width of each written word (8 or 16)
//   BASE_ADDR address of the first header word
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start                  request to generate a header (honoured in IDLE)
//   xMin/xMax/yMin/yMax    inclusive crop bounds
//   bpp_sel                0 = 24 bpp, 1 = 32 bpp
//   waitreq                memory stall; a write is held while it is high
//   addr, wren, wrdata     memory write port
//   busy, done, err        status: working, one-cycle completion, bad bounds
// ---------------------------------------------------------------------------
module bmp_header_gen #(
    parameter int          COORD_W   = 11,
    parameter int          ADDR_W    = 24,
    parameter int          DATA_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] xMin,
    input  logic [COORD_W-1:0] xMax,
    input  logic [COORD_W-1:0] yMin,
    input  logic [COORD_W-1:0] yMax,
    input  logic               bpp_sel,
    input  logic               waitreq,
    output logic [ADDR_W-1:0]  addr,
    output logic               wren,
    output logic [DATA_W-1:0]  wrdata,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int         N_WORDS  = (DATA_W == 8) ? 54 : 27;
    localparam logic [5:0] LAST_IDX = 6'(N_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CALC0,
        CALC1,
        WRITE,
        FIN
    } state_t;

    state_t              state_q, state_d;
    logic [COORD_W-1:0]  x_min_q, x_min_d;
    logic [COORD_W-1:0]  x_max_q, x_max_d;
    logic [COORD_W-1:0]  y_min_q, y_min_d;
    logic [COORD_W-1:0]  y_max_q, y_max_d;
    logic                bpp32_q, bpp32_d;
    logic [31:0]         w_q, w_d;
    logic [31:0]         h_q, h_d;
    logic [31:0]         img_q, img_d;
    logic [31:0]         fsize_q, fsize_d;
    logic [5:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wren_q, wren_d;
    logic [DATA_W-1:0]   wrdata_q, wrdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [31:0]         row;
    logic [31:0]         stride;
    logic [31:0]         img_calc;
    logic [431:0]        hdr;
    logic [8:0]          bit_base;
    logic                load_word;

    // Next-state and next-output logic. All outputs are registered, so each
    // output's _d value describes what the port shows in the state we enter.
    always_comb begin
        state_d   = state_q;
        x_min_d   = x_min_q;
        x_max_d   = x_max_q;
        y_min_d   = y_min_q;
        y_max_d   = y_max_q;
        bpp32_d   = bpp32_q;
        w_d       = w_q;
        h_d       = h_q;
        img_d     = img_q;
        fsize_d   = fsize_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wren_d    = wren_q;
        wrdata_d  = wrdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        load_word = 1'b0;

        // Row length in bytes (3 or 4 per pixel), padded up to a 4-byte boundary.
        row      = bpp32_q ? {w_q[29:0], 2'b00} : (w_q + {w_q[30:0], 1'b0});
        stride   = (row + 32'd3) & ~32'd3;
        img_calc = stride * h_q;

        // Whole header as one vector with byte i at bits [8i+7:8i], which makes
        // every multi-byte field little-endian by construction.
        hdr = {128'd0,                           // bytes 38-53
               img_q,                            // bytes 34-37
               32'd0,                            // bytes 30-33
               (bpp32_q ? 16'd32 : 16'd24),      // bytes 28-29
               16'd1,                            // bytes 26-27
               h_q,                              // bytes 22-25
               w_q,                              // bytes 18-21
               32'd40,                           // bytes 14-17
               32'd54,                           // bytes 10-13
               32'd0,                            // bytes 6-9
               fsize_q,                          // bytes 2-5
               16'h4D42};                        // bytes 0-1 "BM"

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_min_d = xMin;
                    x_max_d = xMax;
                    y_min_d = yMin;
                    y_max_d = yMax;
                    bpp32_d = bpp_sel;
                    if ((xMax < xMin) || (yMax < yMin)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = CALC0;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC0: begin
                // Bounds are ordered here, so the difference cannot wrap.
                w_d     = 32'(x_max_q - x_min_q) + 32'd1;
                h_d     = 32'(y_max_q - y_min_q) + 32'd1;
                state_d = CALC1;
            end
            CALC1: begin
                // img/fsize land in the same edge that presents word 0; word 0
                // holds only the constant magic bytes, so it does not need them.
                img_d     = img_calc;
                fsize_d   = img_calc + 32'd54;
                state_d   = WRITE;
                idx_d     = 6'd0;
                wren_d    = 1'b1;
                load_word = 1'b1;
            end
            WRITE: begin
                if (!waitreq) begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = FIN;
                        wren_d   = 1'b0;
                        addr_d   = '0;
                        wrdata_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d     = idx_q + 6'd1;
                        load_word = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = 6'd0;
            end
            default: begin
                state_d  = IDLE;
                wren_d   = 1'b0;
                addr_d   = '0;
                wrdata_d = '0;
                busy_d   = 1'b0;
            end
        endcase

        bit_base = 9'(idx_d) * 9'(DATA_W);
        if (load_word) begin
            addr_d   = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_d);
            wrdata_d = hdr[bit_base +: DATA_W];
        end
    end

    // State and output registers; reset clears everything including the
    // latched bounds and computed sizes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_min_q  <= '0;
            x_max_q  <= '0;
            y_min_q  <= '0;
            y_max_q  <= '0;
            bpp32_q  <= 1'b0;
            w_q      <= '0;
            h_q      <= '0;
            img_q    <= '0;
            fsize_q  <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            wren_q   <= 1'b0;
            wrdata_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_min_q  <= x_min_d;
            x_max_q  <= x_max_d;
            y_min_q  <= y_min_d;
            y_max_q  <= y_max_d;
            bpp32_q  <= bpp32_d;
            w_q      <= w_d;
            h_q      <= h_d;
            img_q    <= img_d;
            fsize_q  <= fsize_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            wren_q   <= wren_d;
            wrdata_q <= wrdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign addr   = addr_q;
    assign wren   = wren_q;
    assign wrdata = wrdata_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bmp_header_gen.sv
// tb_bmp_header_gen
// ---------------------------------------------------------------------------
// Drives a 16-bit and an 8-bit instance of bmp_header_gen side by side from
// the same stimulus and compares every accepted write against a header
// built from the BMP size rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_bmp_header_gen;

    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] xMin, xMax, yMin, yMax;
    logic        bpp_sel;
    logic        waitreq;

    logic [23:0] addr16, addr8;
    logic        wren16, wren8;
    logic [15:0] wrdata16;
    logic [7:0]  wrdata8;
    logic        busy16, busy8, done16, done8, err16, err8;

    int checks = 0;
    int passed = 0;

    // Reference header bytes and per-run observations.
    logic [7:0]  refBytes [54];
    logic [15:0] q16 [$];
    int          qa16 [$];
    logic [7:0]  q8 [$];
    int          qa8 [$];
    int firstWr16, firstWr8, doneCnt16, doneCnt8, doneCyc16, doneCyc8;
    int busyCnt16, busyCnt8, errCnt16, errCnt8, errCyc16, errCyc8;
    int holdErr16, holdErr8, idleErr16, idleErr8;

    bmp_header_gen #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start),
        .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
        .bpp_sel(bpp_sel), .waitreq(waitreq),
        .addr(addr16), .wren(wren16), .wrdata(wrdata16),
        .busy(busy16), .done(done16), .err(err16)
    );

    bmp_header_gen #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start),
        .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
        .bpp_sel(bpp_sel), .waitreq(waitreq),
        .addr(addr8), .wren(wren8), .wrdata(wrdata8),
        .busy(busy8), .done(done8), .err(err8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Header from the file-format rules: padded row length via division,
    // sizes reduced modulo 2^32, fields laid out little-endian byte by byte.
    function automatic void put32(input int offset, input longint unsigned value);
        for (int i = 0; i < 4; i++) refBytes[offset + i] = 8'((value >> (8 * i)) & 255);
    endfunction

    function automatic void buildRef(input int xmin, input int xmax, input int ymin,
                                     input int ymax, input bit bpp32);
        longint unsigned w, h, rowBytes, stride, img, fsize;
        w        = longint'(xmax - xmin + 1);
        h        = longint'(ymax - ymin + 1);
        rowBytes = w * (bpp32 ? 4 : 3);
        stride   = ((rowBytes + 3) / 4) * 4;
        img      = (stride * h) % 64'h1_0000_0000;
        fsize    = (img + 54) % 64'h1_0000_0000;
        for (int i = 0; i < 54; i++) refBytes[i] = 8'h00;
        refBytes[0] = 8'h42;
        refBytes[1] = 8'h4D;
        put32(2, fsize);
        put32(10, 54);
        put32(14, 40);
        put32(18, w);
        put32(22, h);
        refBytes[26] = 8'd1;
        refBytes[28] = bpp32 ? 8'd32 : 8'd24;
        put32(34, img);
    endfunction

    // One header request. stallWord/stallLen hold waitreq on a given 16-bit
    // word; rstWord asserts reset when the 16-bit instance presents that word;
    // startAtDone raises start in the cycle the 16-bit done pulse is seen.
    task automatic applyStimulus(input int xmin, input int xmax, input int ymin,
                                 input int ymax, input bit bpp32, input int stallWord,
                                 input int stallLen, input bit randStall,
                                 input int rstWord, input bit startAtDone);
        bit errMode;
        bit finished;
        bit prevStall16, prevStall8;
        logic [23:0] prevA16, prevA8;
        logic [15:0] prevD16;
        logic [7:0]  prevD8;
        int stallLeft;
        int cyc;

        errMode = (xmax < xmin) || (ymax < ymin);
        if (!errMode) buildRef(xmin, xmax, ymin, ymax, bpp32);
        q16.delete(); qa16.delete(); q8.delete(); qa8.delete();
        firstWr16 = -1; firstWr8 = -1; doneCnt16 = 0; doneCnt8 = 0;
        doneCyc16 = -1; doneCyc8 = -1; busyCnt16 = 0; busyCnt8 = 0;
        errCnt16 = 0; errCnt8 = 0; errCyc16 = -1; errCyc8 = -1;
        holdErr16 = 0; holdErr8 = 0; idleErr16 = 0; idleErr8 = 0;
        prevStall16 = 0; prevStall8 = 0;
        prevA16 = '0; prevA8 = '0; prevD16 = '0; prevD8 = '0;
        stallLeft = stallLen;
        finished = 0;

        xMin = 11'(xmin); xMax = 11'(xmax); yMin = 11'(ymin); yMax = 11'(ymax);
        bpp_sel = bpp32;
        waitreq = 1'b0;
        start = 1'b1;
        tick();

        for (cyc = 1; cyc < BUDGET && !finished; cyc++) begin
            start = 1'b0;
            waitreq = 1'b0;
            if (wren16 && int'(addr16) == stallWord && stallLeft > 0) begin
                waitreq = 1'b1;
                stallLeft--;
            end else if (randStall) begin
                waitreq = ($urandom_range(3, 0) == 0);
            end

            if (prevStall16 && (!wren16 || addr16 !== prevA16 || wrdata16 !== prevD16)) holdErr16++;
            if (prevStall8 && (!wren8 || addr8 !== prevA8 || wrdata8 !== prevD8)) holdErr8++;
            if (!wren16 && (addr16 !== 24'd0 || wrdata16 !== 16'd0)) idleErr16++;
            if (!wren8 && (addr8 !== 24'd0 || wrdata8 !== 8'd0)) idleErr8++;
            prevStall16 = wren16 && waitreq;
            prevStall8  = wren8 && waitreq;
            prevA16 = addr16; prevD16 = wrdata16; prevA8 = addr8; prevD8 = wrdata8;

            if (wren16 && firstWr16 < 0) firstWr16 = cyc;
            if (wren8 && firstWr8 < 0) firstWr8 = cyc;
            if (wren16 && !waitreq) begin q16.push_back(wrdata16); qa16.push_back(int'(addr16)); end
            if (wren8 && !waitreq) begin q8.push_back(wrdata8); qa8.push_back(int'(addr8)); end
            if (busy16) busyCnt16++;
            if (busy8) busyCnt8++;
            if (err16) begin errCnt16++; errCyc16 = cyc; end
            if (err8) begin errCnt8++; errCyc8 = cyc; end
            if (done16) begin
                doneCnt16++;
                doneCyc16 = cyc;
                if (startAtDone) start = 1'b1;
            end
            if (done8) begin doneCnt8++; doneCyc8 = cyc; end

            if (rstWord >= 0 && wren16 && int'(addr16) == rstWord) begin
                rst = 1'b1;
                tick();
                checkOutput("outputs_after_midrun_reset16",
                            {24'd0, addr16, wrdata16, wren16, busy16, done16, err16}, 64'd0);
                checkOutput("outputs_after_midrun_reset8",
                            {32'd0, addr8, wrdata8, wren8, busy8, done8, err8}, 64'd0);
                rst = 1'b0;
                start = 1'b0;
                waitreq = 1'b0;
                return;
            end

            if (errMode && cyc >= 6) finished = 1;
            if (!errMode && doneCyc16 > 0 && doneCyc8 > 0 &&
                cyc >= ((doneCyc16 > doneCyc8) ? doneCyc16 : doneCyc8) + 3) finished = 1;
            tick();
        end
        start = 1'b0;
        waitreq = 1'b0;

        if (errMode) begin
            checkOutput("err_pulses16", errCnt16, 1);
            checkOutput("err_cycle16", errCyc16, 1);
            checkOutput("err_pulses8", errCnt8, 1);
            checkOutput("err_no_busy16", busyCnt16, 0);
            checkOutput("err_no_busy8", busyCnt8, 0);
            checkOutput("err_no_writes", firstWr16 + firstWr8, -2);
            checkOutput("err_no_done", doneCnt16 + doneCnt8, 0);
        end else begin
            checkOutput("run_completes", finished, 1);
            checkOutput("write_count16", q16.size(), 27);
            checkOutput("write_count8", q8.size(), 54);
            for (int k = 0; k < 27; k++) begin
                checkOutput($sformatf("word16[%0d]", k),
                            (k < q16.size()) ? {48'd0, q16[k]} : 64'hx,
                            {48'd0, refBytes[2 * k + 1], refBytes[2 * k]});
                checkOutput($sformatf("addr16[%0d]", k),
                            (k < qa16.size()) ? 64'(qa16[k]) : 64'hx, 64'(k));
            end
            for (int k = 0; k < 54; k++) begin
                checkOutput($sformatf("byte8[%0d]", k),
                            (k < q8.size()) ? {56'd0, q8[k]} : 64'hx, {56'd0, refBytes[k]});
                checkOutput($sformatf("addr8[%0d]", k),
                            (k < qa8.size()) ? 64'(qa8[k]) : 64'hx, 64'(k));
            end
            checkOutput("first_write_cycle16", firstWr16, 3);
            checkOutput("first_write_cycle8", firstWr8, 3);
            checkOutput("done_pulses16", doneCnt16, 1);
            checkOutput("done_pulses8", doneCnt8, 1);
            checkOutput("busy_cycles16", busyCnt16, doneCyc16);
            checkOutput("busy_cycles8", busyCnt8, doneCyc8);
            checkOutput("hold_during_stall16", holdErr16, 0);
            checkOutput("hold_during_stall8", holdErr8, 0);
            checkOutput("idle_outputs_zero16", idleErr16, 0);
            checkOutput("idle_outputs_zero8", idleErr8, 0);
            checkOutput("no_err_on_valid", errCnt16 + errCnt8, 0);
        end
    endtask

    initial begin
        int xa, xb, ya, yb;
        rst = 1'b1; start = 1'b0; waitreq = 1'b0; bpp_sel = 1'b0;
        xMin = '0; xMax = '0; yMin = '0; yMax = '0;
        tick();
        tick();
        checkOutput("reset_state16", {24'd0, addr16, wrdata16, wren16, busy16, done16, err16}, 64'd0);
        checkOutput("reset_state8", {32'd0, addr8, wrdata8, wren8, busy8, done8, err8}, 64'd0);

        // Reset wins over a simultaneous start.
        xMin = 11'd0; xMax = 11'd9; yMin = 11'd0; yMax = 11'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        tick();
        checkOutput("reset_beats_start16", busy16, 0);
        checkOutput("reset_beats_start8", busy8, 0);

        $display("[TB] 100x100 at 24 bpp");
        applyStimulus(0, 99, 0, 99, 0, -1, 0, 0, -1, 0);
        checkOutput("spec_word0", q16.size() > 0 ? q16[0] : 16'hx, 16'h4D42);
        checkOutput("spec_word1", q16.size() > 1 ? q16[1] : 16'hx, 16'h7566);
        checkOutput("spec_word2", q16.size() > 2 ? q16[2] : 16'hx, 16'h0000);
        checkOutput("spec_word9", q16.size() > 9 ? q16[9] : 16'hx, 16'h0064);
        checkOutput("spec_word14", q16.size() > 14 ? q16[14] : 16'hx, 16'h0018);
        checkOutput("spec_word17", q16.size() > 17 ? q16[17] : 16'hx, 16'h7530);

        $display("[TB] padded 5x2 crop");
        applyStimulus(3, 7, 0, 1, 0, -1, 0, 0, -1, 0);
        checkOutput("pad_fsize", q16.size() > 1 ? q16[1] : 16'hx, 16'h0056);
        checkOutput("pad_img", q16.size() > 17 ? q16[17] : 16'hx, 16'h0020);

        $display("[TB] 3x1 crop at 32 bpp");
        applyStimulus(0, 2, 0, 0, 1, -1, 0, 0, -1, 0);
        checkOutput("b8_byte2", q8.size() > 2 ? q8[2] : 8'hx, 8'h42);
        checkOutput("b8_byte28", q8.size() > 28 ? q8[28] : 8'hx, 8'h20);
        checkOutput("b8_byte34", q8.size() > 34 ? q8[34] : 8'hx, 8'h0C);

        $display("[TB] inverted bounds");
        applyStimulus(10, 5, 0, 4, 0, -1, 0, 0, -1, 0);
        applyStimulus(0, 4, 8, 7, 1, -1, 0, 0, -1, 0);

        $display("[TB] four-cycle stall on word 5");
        applyStimulus(0, 99, 0, 99, 0, 5, 4, 0, -1, 0);

        $display("[TB] reset at word 10, then a fresh header");
        applyStimulus(0, 99, 0, 99, 0, -1, 0, 0, 10, 0);
        applyStimulus(0, 99, 0, 99, 1, -1, 0, 0, -1, 0);

        $display("[TB] start coinciding with done");
        applyStimulus(1, 20, 2, 30, 0, -1, 0, 0, -1, 1);

        $display("[TB] randomized crops with random stalls");
        for (int r = 0; r < 8; r++) begin
            xa = int'($urandom_range(2047, 0));
            xb = int'($urandom_range(2047, xa));
            ya = int'($urandom_range(2047, 0));
            yb = int'($urandom_range(2047, ya));
            applyStimulus(xa, xb, ya, yb, 1'($urandom_range(1, 0)), -1, 0, 1, -1, r[0]);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bmp_header_gen.md
BMP_HEADER_GEN -- requirements
Module: bmp_header_gen

Interface
REQ-001 SHALL provide parameter COORD_W, default 11: width of the crop coordinate inputs.
REQ-002 SHALL provide parameter ADDR_W, default 24: width of the write address.
REQ-003 SHALL provide parameter DATA_W, default 16, legal values 8 or 16: width of each write word.
REQ-004 SHALL provide parameter BASE_ADDR, default 0: address of the first header word.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: request to generate a header.
REQ-008 SHALL have ports xMin, xMax, yMin, yMax, each input, COORD_W bits: inclusive crop bounds.
REQ-009 SHALL have port bpp_sel, input, 1 bit: 0 selects 24 bpp, 1 selects 32 bpp.
REQ-010 SHALL have port waitreq, input, 1 bit: memory stall; a write is not accepted while it is high.
REQ-011 SHALL have port addr, output, ADDR_W bits: write address.
REQ-012 SHALL have port wren, output, 1 bit: write strobe.
REQ-013 SHALL have port wrdata, output, DATA_W bits: write data.
REQ-014 SHALL have ports busy, done and err, each output, 1 bit: status outputs.

Function
REQ-015 SHALL implement states IDLE, CALC0, CALC1, WRITE and FIN.
REQ-016 In IDLE with start=1, SHALL latch all coordinates and bpp_sel; start is ignored in every other state.
REQ-017 If latched xMax<xMin or yMax<yMin, SHALL pulse err for exactly one cycle (the cycle after start), stay in IDLE, and issue no write.
REQ-018 Otherwise SHALL pass through CALC0 then CALC1, one cycle each, and compute:
- W = xMax-xMin+1 and H = yMax-yMin+1, each zero-extended to 32 bits;
- row = W*3 (24 bpp) or W*4 (32 bpp);
- stride = (row+3) & ~3;
- img = stride*H, truncated to 32 bits;
- fsize = img+54, modulo 2^32.
REQ-019 SHALL build a 54-byte header; every multi-byte field is little-endian:
- bytes 0-1: 0x42, 0x4D;
- bytes 2-5: fsize;
- bytes 6-9: 0;
- bytes 10-13: 54;
- bytes 14-17: 40;
- bytes 18-21: W;
- bytes 22-25: H;
- bytes 26-27: 1;
- bytes 28-29: 24 or 32;
- bytes 30-33: 0;
- bytes 34-37: img;
- bytes 38-53: 0.
REQ-020 In WRITE, SHALL issue N words, N = 54 when DATA_W=8 and N = 27 when DATA_W=16.
REQ-021 Word k SHALL go to addr = BASE_ADDR+k; for DATA_W=16, wrdata = {byte[2k+1], byte[2k]}.
REQ-022 wren SHALL be high in every WRITE cycle; addr, wren and wrdata SHALL hold stable while waitreq=1.
REQ-023 A word SHALL be accepted when wren=1 and waitreq=0; the next word is presented the following cycle.
REQ-024 With waitreq held low, the first write SHALL appear 3 cycles after the start cycle, with no gaps between words.
REQ-025 After the last word is accepted, SHALL enter FIN, hold done=1 for exactly one cycle, and return to IDLE.
REQ-026 busy SHALL be 1 in CALC0, CALC1, WRITE and FIN, and 0 in IDLE.
REQ-027 Outside WRITE, SHALL drive wren=0, addr=0 and wrdata=0.
REQ-028 A start arriving in the same cycle as done SHALL be ignored; a new start is honoured from the IDLE cycle that follows.

Reset
REQ-029 When rst=1 at a clock edge, SHALL enter IDLE regardless of current state, including mid-WRITE.
REQ-030 During and after reset, SHALL drive wren, done, err and busy to 0 and addr and wrdata to 0; latched values are discarded.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification
REQ-032 Stimulus: DATA_W=16, x 0..99, y 0..99, 24 bpp, waitreq=0.
-> 27 writes to addresses 0..26, first 3 cycles after start.
-> word0 = 0x4D42, word1 = 0x7566, word2 = 0x0000.
-> word17 = 0x7530, word9 = 0x0064, word14 = 0x0018.
-> done pulses once.
REQ-033 Stimulus: x 3..7, y 0..1, 24 bpp.
-> W = 5, row = 15, stride = 16, img = 32 (0x20), fsize = 86 (0x56).
REQ-034 Stimulus: DATA_W=8, x 0..2, y 0..0, 32 bpp.
-> 54 writes; byte 2 = 0x42 (fsize 66), byte 28 = 0x20, byte 34 = 0x0C.
REQ-035 Stimulus: xMin=10, xMax=5.
-> err high for one cycle, no wren, busy stays 0.
REQ-036 Stimulus: waitreq high for 4 cycles on word 5.
-> addr = 5 and wrdata held for those 4 cycles; no word skipped or duplicated; total accepted writes = 27.
REQ-037 Stimulus: rst asserted at word 10, then a new start.
-> outputs go to 0 the cycle after reset; the next run restarts at addr 0 with a full header.
